// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width and 2-bit branch counter encodings.
package cpu_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating direction counter: next state from current state and outcome.
module sat_ctr2
    import cpu_pkg::*;
(
    input  ctr_t state,
    input  logic taken,
    output ctr_t state_next
);

    always_comb begin
        state_next = state;
        unique case (state)
            SNT: state_next = taken ? WNT : SNT;
            WNT: state_next = taken ? WT  : SNT;
            WT:  state_next = taken ? ST  : WNT;
            ST:  state_next = taken ? ST  : WT;
            default: state_next = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters feeding IF prediction/control_pc.
// Define BP_STATS_EN to add resolved-branch and mispredict counters.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] cpc,
    output logic            prediction,
    output logic [PC_W-1:0] control_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
`ifdef BP_STATS_EN
    input  logic            upd_pred,
    output logic [PC_W-1:0] br_count,
    output logic [PC_W-1:0] mis_count
`else
    input  logic            upd_pred
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    ctr_t              ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    ctr_t              upd_ctr_next;

    // Word-aligned PCs: the low two bits never take part in addressing.
    logic unused_pc_bits;
`ifdef BP_STATS_EN
    assign unused_pc_bits = ^{cpc[1:0], upd_pc[1:0]};
`else
    assign unused_pc_bits = ^{cpc[1:0], upd_pc[1:0], upd_pred};
`endif

    // Asynchronous lookup of registered state only.
    assign rd_idx     = cpc[IDX_W+1:2];
    assign rd_tag     = cpc[PC_W-1:IDX_W+2];
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign prediction = rd_hit && ctr_q[rd_idx][1];
    assign control_pc = prediction ? target_q[rd_idx] : PC_W'(0);

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_ctr2 u_sat_ctr2 (
        .state      (ctr_q[upd_idx]),
        .taken      (upd_taken),
        .state_next (upd_ctr_next)
    );

    // Training: hits move the counter, taken misses allocate/replace the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= WT;
            end
        end
    end

`ifdef BP_STATS_EN
    // Free-running statistics; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (upd_valid) begin
            br_count <= br_count + PC_W'(1);
            if (upd_pred != upd_taken) begin
                mis_count <= mis_count + PC_W'(1);
            end
        end
    end
`endif

endmodule
